// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, instruction fields,
// flag bit positions and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd11;
    localparam logic [3:0] OP_LDI = 4'd15;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam int FLG_C = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_N = 1;
    localparam int FLG_V = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;

    // LDI counts as legal; callers separate it from the ALU ops.
    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LDI: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: one synchronous write port, two asynchronous operand reads and an
// asynchronous debug read; cleared by the asynchronous reset.
module alu_regfile #(
    parameter int AW = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] dbg_data
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Control stage in front of the 8-bit combinational ALU: decodes instructions, stages
// operands, writes results back and keeps the sticky {C,Z,N,V} flag register.
//
// state   | meaning
// IDLE    | ready for an instruction; LDI and illegal ops complete here
// READ    | operands and opcode loaded into the ALU input registers
// EXEC    | ALU inputs stable; result and flags captured at the closing edge
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int         REG_AW    = 3,
    parameter int         DATA_W    = 8,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags,
    output logic              done,
    output logic              err,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [1:0]        state;
    logic [3:0]        op_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;

    logic [3:0]        instr_op;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs1;
    logic [REG_AW-1:0] instr_rs2;
    logic [DATA_W-1:0] instr_imm;
    logic              accept;
    logic              is_ldi;
    logic              is_alu;

    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    assign instr_op    = instr[OP_MSB:OP_LSB];
    assign instr_rd    = instr[RD_MSB:RD_LSB];
    assign instr_rs1   = instr[RS1_MSB:RS1_LSB];
    assign instr_rs2   = instr[RS2_MSB:RS2_LSB];
    assign instr_imm   = instr[IMM_MSB:IMM_LSB];

    assign instr_ready = (state == ST_IDLE);
    assign accept      = instr_valid && instr_ready;
    assign is_ldi      = (instr_op == OP_LDI);
    assign is_alu      = is_legal_op(instr_op) && !is_ldi;

    // LDI writes at its accept edge; ALU results write at the edge closing EXEC.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_out;
        if (state == ST_EXEC) begin
            rf_we = 1'b1;
        end else if (accept && is_ldi) begin
            rf_we    = 1'b1;
            rf_waddr = instr_rd;
            rf_wdata = instr_imm;
        end
    end

    alu_regfile #(
        .AW (REG_AW),
        .DW (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .raddr1   (rs1_q),
        .raddr2   (rs2_q),
        .dbg_addr (dbg_addr),
        .rdata1   (rf_rdata1),
        .rdata2   (rf_rdata2),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            alu_in1 <= '0;
            alu_in2 <= '0;
            alu_op  <= '0;
            flags   <= FLAGS_RST;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_alu) begin
                            op_q  <= instr_op;
                            rd_q  <= instr_rd;
                            rs1_q <= instr_rs1;
                            rs2_q <= instr_rs2;
                            state <= ST_READ;
                        end else if (is_ldi) begin
                            done <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    alu_in1 <= rf_rdata1;
                    alu_in2 <= rf_rdata2;
                    alu_op  <= op_q;
                    state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    // The ALU's C and V are only meaningful for ADD.
                    if (alu_op == OP_ADD) begin
                        flags <= alu_flags;
                    end else begin
                        flags[FLG_Z] <= alu_flags[FLG_Z];
                        flags[FLG_N] <= alu_flags[FLG_N];
                    end
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    logic [3:0]  alu_op;
    logic [7:0]  alu_out;
    logic [3:0]  alu_flags;
    logic [3:0]  flags;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit         is_err;
        logic [2:0] rd;
        logic [7:0] val;
        logic [3:0] flg;
        int         due;
    } exp_t;

    exp_t       sb[$];
    bit         ready_log[$];
    logic [7:0] mreg[8];
    logic [3:0] mflags;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_flags   (alu_flags),
        .flags       (flags),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Reference ALU: returns {C,Z,N,V,result}; V uses the add-overflow formula for every op.
    function automatic logic [11:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic       c;
        s = 9'd0;
        r = 8'd0;
        c = 1'b0;
        case (op)
            4'd0:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
            4'd1:  begin r = a - b; c = (a < b); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd11: r = ~a;
            default: r = 8'd0;
        endcase
        return {c, (r == 8'd0), r[7], (a[7] == b[7]) && (r[7] != a[7]), r};
    endfunction

    always_comb begin
        logic [11:0] res;
        res       = alu_ref(alu_op, alu_in1, alu_in2);
        alu_out   = res[7:0];
        alu_flags = res[11:8];
    end

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {4'hF, rd, 1'b0, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [7:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 8'd0;
        mflags = 4'b0000;
        sb.delete();
    endtask

    task automatic model_accept(input logic [15:0] ins);
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [11:0] res;
        exp_t        e;
        op = ins[15:12];
        rd = ins[11:9];
        e.is_err = 1'b0;
        e.rd     = rd;
        e.val    = 8'd0;
        e.due    = cyc;
        if (op == 4'hF) begin
            mreg[rd] = ins[7:0];
            e.val    = ins[7:0];
        end else if (op <= 4'd4 || op == 4'd11) begin
            res      = alu_ref(op, mreg[ins[8:6]], mreg[ins[5:3]]);
            mreg[rd] = res[7:0];
            mflags   = (op == 4'd0) ? res[11:8] : {mflags[3], res[10], res[9], mflags[0]};
            e.val    = res[7:0];
            e.due    = cyc + 2;
        end else begin
            e.is_err = 1'b1;
        end
        e.flg = mflags;
        sb.push_back(e);
    endtask

    task automatic cycle();
        logic        acc;
        logic [15:0] ins;
        logic [7:0]  d;
        exp_t        e;
        acc = instr_valid && instr_ready;
        ins = instr;
        if (instr_valid) ready_log.push_back(instr_ready);
        @(posedge clk);
        #1;
        cyc++;
        if (acc) model_accept(ins);
        if (sb.size() != 0 && sb[0].due < cyc) begin
            chk("missed_pulse", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (done || err) begin
            chk("done_err_excl", {31'd0, done & err}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
                chk("latency", cyc, e.due);
                chk("flags", {28'd0, flags}, {28'd0, e.flg});
                if (!e.is_err) begin
                    read_reg(e.rd, d);
                    chk("wb_data", {24'd0, d}, {24'd0, e.val});
                end
            end
        end
    endtask

    task automatic send(input logic [15:0] ins, input bit hold);
        bit was;
        instr       = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            was = instr_ready;
            cycle();
            if (was) break;
            if (i == 7) chk("accept_timeout", 32'd0, 32'd1);
        end
        if (!hold) instr_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
        chk("drain", sb.size(), 32'd0);
        cycle();
    endtask

    initial begin
        logic [7:0] d;
        bit         exp_ready[7];
        exp_ready   = '{1, 0, 0, 1, 0, 0, 1};
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_alu_regs", {12'd0, alu_in1, alu_in2, alu_op}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            chk("rst_reg", {24'd0, d}, 32'd0);
        end
        rst_n = 1'b1;
        cycle();

        // ADD with carry out
        send(ldi(3'd1, 8'hF0), 1'b1);
        send(ldi(3'd2, 8'h20), 1'b1);
        send(enc(4'd0, 3'd3, 3'd1, 3'd2), 1'b0);
        drain();
        read_reg(3'd3, d);
        chk("t1_r3", {24'd0, d}, 32'h10);
        chk("t1_flags", {28'd0, flags}, 32'b1000);

        // ADD with signed overflow
        send(ldi(3'd1, 8'h70), 1'b1);
        send(ldi(3'd2, 8'h10), 1'b1);
        send(enc(4'd0, 3'd4, 3'd1, 3'd2), 1'b0);
        drain();
        read_reg(3'd4, d);
        chk("t2_r4", {24'd0, d}, 32'h80);
        chk("t2_flags", {28'd0, flags}, 32'b0011);

        // SUB keeps C and V
        send(enc(4'd1, 3'd5, 3'd2, 3'd2), 1'b0);
        drain();
        read_reg(3'd5, d);
        chk("t3_r5", {24'd0, d}, 32'h00);
        chk("t3_flags", {28'd0, flags}, 32'b0101);

        // Illegal opcode
        send(enc(4'd5, 3'd1, 3'd2, 3'd3), 1'b0);
        chk("t4_ready_back", {31'd0, instr_ready}, 32'd1);
        drain();
        chk("t4_flags", {28'd0, flags}, 32'b0101);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), d);
            chk("t4_reg", {24'd0, d}, {24'd0, mreg[i]});
        end

        // Back-to-back ADDs with valid held
        ready_log.delete();
        send(enc(4'd0, 3'd7, 3'd1, 3'd2), 1'b1);
        send(enc(4'd0, 3'd0, 3'd7, 3'd1), 1'b1);
        send(enc(4'd0, 3'd3, 3'd0, 3'd2), 1'b0);
        chk("t5_ready_len", ready_log.size(), 32'd7);
        for (int i = 0; i < 7 && i < ready_log.size(); i++) begin
            chk("t5_ready_pat", {31'd0, ready_log[i]}, {31'd0, exp_ready[i]});
        end
        drain();
        read_reg(3'd3, d);
        chk("t5_r3", {24'd0, d}, 32'h00);
        chk("t5_flags", {28'd0, flags}, 32'b1100);

        // Logic ops and a rd==rs1 hazard
        send(ldi(3'd1, 8'h5A), 1'b1);
        send(ldi(3'd2, 8'h0F), 1'b0);
        send(enc(4'd2, 3'd3, 3'd1, 3'd2), 1'b0);
        send(enc(4'd3, 3'd4, 3'd1, 3'd2), 1'b0);
        send(enc(4'd4, 3'd5, 3'd1, 3'd2), 1'b0);
        send(enc(4'd11, 3'd2, 3'd2, 3'd0), 1'b0);
        drain();
        read_reg(3'd2, d);
        chk("t6_not_r2", {24'd0, d}, 32'hF0);

        // Reset during EXEC aborts the write
        send(enc(4'd0, 3'd6, 3'd1, 3'd2), 1'b0);
        chk("t7_in_read", {31'd0, instr_ready}, 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t7_done_low", {31'd0, done}, 32'd0);
        chk("t7_flags_rst", {28'd0, flags}, 32'd0);
        read_reg(3'd6, d);
        chk("t7_r6", {24'd0, d}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) cycle();
        chk("t7_idle", {31'd0, instr_ready}, 32'd1);
        read_reg(3'd6, d);
        chk("t7_r6_after", {24'd0, d}, 32'd0);
        read_reg(3'd1, d);
        chk("t7_r1_after", {24'd0, d}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
